// File: rtl/seq_detect_event_logger.sv
// rtl/seq_detect_event_logger.sv - counts 1010 detector matches and logs their bit positions in a show-ahead FIFO
//
// Ports:
//   clk, rst     single clock, synchronous active-high reset
//   en           bit stream active; bit position advances only when 1
//   det_in       match pulse from the sequence detector, aligned with the current bit
//   clr          synchronous soft clear, same effect as rst
//   rd_en        pop request for the FIFO head
//   rd_data      timestamp at the FIFO head (0 when empty)
//   empty, full  FIFO occupancy flags
//   level        number of entries held, 0..DEPTH
//   det_count    saturating count of accepted detections
//   overflow     sticky flag, a detection was dropped because the FIFO was full
module seq_detect_event_logger #(
    parameter int TS_W   = 16,
    parameter int CNT_W  = 16,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              det_in,
    input  logic              clr,
    input  logic              rd_en,
    output logic [TS_W-1:0]   rd_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   level,
    output logic [CNT_W-1:0]  det_count,
    output logic              overflow
);

    localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [TS_W-1:0]   bit_pos_q, bit_pos_d;
    logic [CNT_W-1:0]  det_count_q, det_count_d;
    logic              overflow_q, overflow_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic [TS_W-1:0]   mem_q [DEPTH];
    logic [TS_W-1:0]   mem_d [DEPTH];

    logic accept;
    logic is_empty;
    logic is_full;
    logic pop;
    logic push;

    always_comb begin
        accept   = en & det_in;
        is_empty = (level_q == '0);
        is_full  = (level_q == DEPTH_L);
        pop      = rd_en & ~is_empty;
        // A pop in the same cycle frees the head slot, so a full FIFO can still take the push.
        push     = accept & (~is_full | pop);

        bit_pos_d   = bit_pos_q;
        det_count_d = det_count_q;
        overflow_d  = overflow_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        level_d     = level_q;
        mem_d       = mem_q;

        if (clr) begin
            bit_pos_d   = '0;
            det_count_d = '0;
            overflow_d  = 1'b0;
            wptr_d      = '0;
            rptr_d      = '0;
            level_d     = '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
        end else begin
            if (en) begin
                bit_pos_d = bit_pos_q + 1'b1;
            end
            if (accept && det_count_q != CNT_MAX) begin
                det_count_d = det_count_q + 1'b1;
            end
            if (accept && !push) begin
                overflow_d = 1'b1;
            end
            if (push) begin
                // Timestamp is the position of the matching bit, before this cycle's increment.
                mem_d[wptr_q] = bit_pos_q;
                wptr_d        = wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_d = rptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_pos_q   <= '0;
            det_count_q <= '0;
            overflow_q  <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            level_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            bit_pos_q   <= bit_pos_d;
            det_count_q <= det_count_d;
            overflow_q  <= overflow_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            level_q     <= level_d;
            mem_q       <= mem_d;
        end
    end

    // Show-ahead head, masked so a stale slot never leaks out while empty.
    assign rd_data   = is_empty ? '0 : mem_q[rptr_q];
    assign empty     = is_empty;
    assign full      = is_full;
    assign level     = level_q;
    assign det_count = det_count_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_seq_detect_event_logger.sv
// tb/tb_seq_detect_event_logger.sv - randomized and directed check of seq_detect_event_logger against a queue model
module tb_seq_detect_event_logger;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic det_in = 1'b0;
    logic clr = 1'b0;
    logic rd_en = 1'b0;

    logic [15:0] rd_data;
    logic        empty;
    logic        full;
    logic [2:0]  level;
    logic [15:0] det_count;
    logic        overflow;

    logic [3:0]  s_rd_data;
    logic        s_empty;
    logic        s_full;
    logic [2:0]  s_level;
    logic [2:0]  s_det_count;
    logic        s_overflow;

    int vectors = 0;
    int miscompares = 0;

    // Reference: timestamps kept as unbounded integers, narrowed only when compared.
    int m_q[$];
    int m_cnt = 0;
    bit m_ovf = 1'b0;
    int m_pos = 0;

    logic [2:0] hist = 3'b000;

    always #5 clk = ~clk;

    seq_detect_event_logger u_dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .det_in    (det_in),
        .clr       (clr),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .level     (level),
        .det_count (det_count),
        .overflow  (overflow)
    );

    seq_detect_event_logger #(
        .TS_W   (4),
        .CNT_W  (3),
        .DEPTH  (4),
        .ADDR_W (2)
    ) u_dut_small (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .det_in    (det_in),
        .clr       (clr),
        .rd_en     (rd_en),
        .rd_data   (s_rd_data),
        .empty     (s_empty),
        .full      (s_full),
        .level     (s_level),
        .det_count (s_det_count),
        .overflow  (s_overflow)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update(input bit r, input bit c, input bit e, input bit d, input bit rd);
        bit did_pop;
        if (r || c) begin
            m_q.delete();
            m_cnt = 0;
            m_ovf = 1'b0;
            m_pos = 0;
        end else begin
            did_pop = rd && (m_q.size() > 0);
            if (did_pop) void'(m_q.pop_front());
            if (e && d) begin
                m_cnt++;
                if (m_q.size() < 4) m_q.push_back(m_pos);
                else m_ovf = 1'b1;
            end
            if (e) m_pos++;
        end
    endtask

    task automatic check_all();
        int head;
        head = (m_q.size() > 0) ? m_q[0] : 0;
        check_val("level",       level,       m_q.size());
        check_val("empty",       empty,       m_q.size() == 0);
        check_val("full",        full,        m_q.size() == 4);
        check_val("rd_data",     rd_data,     head % 65536);
        check_val("det_count",   det_count,   (m_cnt > 65535) ? 65535 : m_cnt);
        check_val("overflow",    overflow,    m_ovf);
        check_val("s_level",     s_level,     m_q.size());
        check_val("s_rd_data",   s_rd_data,   head % 16);
        check_val("s_det_count", s_det_count, (m_cnt > 7) ? 7 : m_cnt);
        check_val("s_overflow",  s_overflow,  m_ovf);
    endtask

    task automatic step(input bit r, input bit c, input bit e, input bit d, input bit rd);
        rst = r;
        clr = c;
        en = e;
        det_in = d;
        rd_en = rd;
        @(posedge clk);
        model_update(r, c, e, d, rd);
        #1;
        check_all();
    endtask

    // Overlapping 1010 Mealy reference: match when the last three bits were 101 and this bit is 0.
    task automatic send_bit(input bit b);
        bit m;
        m = (hist == 3'b101) && (b == 1'b0);
        hist = {hist[1:0], b};
        step(0, 0, 1, m, 0);
    endtask

    initial begin
        logic [10:0] stream;
        stream = 11'b10011010101;

        // Reset state
        step(1, 0, 0, 0, 0);
        check_val("rst_empty", empty, 1);
        check_val("rst_rd_data", rd_data, 0);

        // Detector stream, matches at bit positions 7 and 9
        hist = 3'b000;
        for (int i = 10; i >= 0; i--) send_bit(stream[i]);
        step(0, 0, 0, 0, 0);
        check_val("stream_count", det_count, 2);
        check_val("stream_level", level, 2);
        check_val("stream_head0", rd_data, 7);
        step(0, 0, 0, 0, 1);
        check_val("stream_head1", rd_data, 9);
        check_val("stream_level1", level, 1);
        step(0, 0, 0, 0, 1);
        check_val("stream_empty", empty, 1);

        // Overflow after five back-to-back detections
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 0);
        check_val("ovf_level", level, 4);
        check_val("ovf_full", full, 1);
        check_val("ovf_count", det_count, 5);
        check_val("ovf_flag", overflow, 1);
        check_val("ovf_head", rd_data, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);

        // Push and pop together while full
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 0);
        step(0, 0, 1, 1, 1);
        check_val("pp_level", level, 4);
        check_val("pp_ovf", overflow, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
        check_val("pp_drained", empty, 1);

        // Detections ignored while en=0, pop ignored while empty
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, 1, 0);

        // clr with entries and overflow, concurrent detection not logged
        for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 0);
        step(0, 1, 1, 1, 1);
        check_val("clr_level", level, 0);
        check_val("clr_count", det_count, 0);
        check_val("clr_ovf", overflow, 0);
        step(0, 0, 1, 1, 0);
        check_val("clr_pos0", rd_data, 0);

        // Narrow timestamp wrap 15 -> 0, then narrow count saturation
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 15; i++) step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0);
        step(0, 0, 1, 1, 0);
        check_val("wrap_head", s_rd_data, 15);
        step(0, 0, 0, 0, 1);
        check_val("wrap_next", s_rd_data, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 1, 1);
        check_val("sat_small", s_det_count, 7);
        check_val("sat_wide", det_count, 10);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            step(($urandom % 400) == 0, ($urandom % 150) == 0, ($urandom % 4) != 0,
                 ($urandom % 3) == 0, ($urandom % 5) < 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seq_detect_event_logger.md
Name: seq_detect_event_logger

Overview:
- Downstream consumer of the overlapping 1010 Mealy sequence detector. Takes the detector's one-bit match output and counts matches.
- Records the bit-stream position (timestamp) of each match in a small FIFO. The FIFO is drained by a host or test controller through a read handshake.
- Runs on the same single clock as the detector, so one det_in sample equals one serial bit period.

Parameters:
TS_W, 16, width of bit-position counter and of each FIFO timestamp entry
CNT_W, 16, width of total detection counter
DEPTH, 4, FIFO entries; power of two, minimum 2
ADDR_W, 2, log2(DEPTH)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  bit stream active; bit position advances and detections are accepted only when 1
det_in  input  1  match pulse from the sequence detector (data_out of detector), aligned with current bit
clr  input  1  synchronous soft clear of all state, same effect as rst
rd_en  input  1  pop request for FIFO head
rd_data  output  TS_W  timestamp at FIFO head (show-ahead), meaningful only when empty=0
empty  output  1  FIFO holds no entries
full  output  1  FIFO holds DEPTH entries
level  output  ADDR_W+1  number of entries held, 0..DEPTH
det_count  output  CNT_W  total accepted detections, saturating
overflow  output  1  sticky: a detection was dropped because FIFO was full

Behaviour:
- Reset (rst=1 at clock edge):
  - bit_pos=0, det_count=0, overflow=0.
  - FIFO pointers=0, level=0, empty=1, full=0.
  - rd_data=0, because the memory head is masked to 0 when empty.
- Priority per edge: rst > clr > normal operation. clr is identical to rst and ignores en, det_in and rd_en in that cycle.
- bit_pos (internal, TS_W bits):
  - Increments by 1 on every edge with en=1 and holds when en=0.
  - Wraps from 2^TS_W-1 to 0 silently.
- Accepted detection: en=1 and det_in=1 at the edge. Its timestamp is the bit_pos value before the increment in that cycle. det_in with en=0 is ignored entirely.
- det_count increments on each accepted detection and saturates at 2^CNT_W-1 (no wrap).
- FIFO push (accepted detection):
  - Writes the timestamp at the write pointer and increments wptr mod DEPTH.
  - If full and no pop this cycle: entry dropped, FIFO unchanged, overflow set to 1. det_count still increments.
- FIFO pop: rd_en=1 and empty=0 → rptr increments mod DEPTH. rd_en with empty=1 is ignored with no error.
- Simultaneous push and pop:
  - Both occur and level is unchanged.
  - This is allowed when full: the slot freed by the pop accepts the push, no drop, overflow unchanged.
  - This is allowed when empty only if the pop is ignored: the push occurs and level becomes 1.
- Flags:
  - level is a registered counter; empty=(level==0), full=(level==DEPTH).
  - All outputs update on the edge following the event, so latency is 1 clock from det_in to level, empty and rd_data.
- rd_data is driven combinationally from memory at rptr (show-ahead). After a pop, the next entry appears the following cycle.
- overflow clears only on rst or clr.
- Reset mid-operation discards FIFO contents immediately; no partial state survives.

Test Plan:
- Reset then stream 10011010101 MSB-first through the detector with en=1 from the first bit → det_in pulses at bit_pos 7 and 9. Then det_count=2, level=2, rd_data=7. Pop → rd_data=9, level=1. Pop → empty=1.
- Pulse det_in for 5 cycles with en=1, DEPTH=4, no reads → level=4, full=1, det_count=5, overflow=1. Stored timestamps are the first four positions.
- FIFO full, det_in=1 and rd_en=1 in the same cycle → level stays 4, overflow stays 0, and the new timestamp is at the tail (pops yield order preserved).
- det_in=1 with en=0 for 3 cycles → det_count, level and bit_pos unchanged. rd_en on empty FIFO → no change, empty=1.
- Assert clr with 2 entries and overflow=1, while det_in=1 in the same cycle → next cycle level=0, det_count=0, overflow=0, bit_pos=0. The concurrent detection is not logged.
- Force bit_pos to 2^TS_W-1 (use TS_W=4 build: 15 en cycles), detection at 15 then next at 0 → entries 15 and 0 in order. Drive det_count to max with CNT_W=3 → holds at 7.
